// File: rtl/rtc_calendar.sv
// BCD time-of-day and Gregorian calendar counter advanced by rising edges of a 1 Hz tick,
// with validated parallel load of all six fields.
module rtc_calendar #(
    parameter logic [15:0] RST_YEAR  = 16'h2000,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        run,
    input  logic        set_load,
    input  logic [7:0]  set_sec,
    input  logic [7:0]  set_min,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_month,
    input  logic [15:0] set_year,
    output logic [7:0]  sec,
    output logic [7:0]  min,
    output logic [7:0]  hour,
    output logic [7:0]  day,
    output logic [7:0]  month,
    output logic [15:0] year,
    output logic        sec_pulse,
    output logic        day_pulse,
    output logic        set_err
);

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        if (v[7:0] == 8'h99) begin
            if (v[15:8] == 8'h99) return 16'h0000;
            else                  return {bcd_inc8(v[15:8]), 8'h00};
        end
        return {v[15:8], bcd_inc8(v[7:0])};
    endfunction

    function automatic logic digits_ok8(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // A BCD byte is a multiple of 4 when (even tens, units 0/4/8) or (odd tens, units 2/6).
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] != 8'h00) return bcd_div4(y[7:0]);
        else                 return bcd_div4(y[15:8]);
    endfunction

    // Returns 00 for an out-of-range month so any day check against it fails.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:   return is_leap(y) ? 8'h29 : 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    logic        r_tick_d;
    logic [7:0]  r_sec, r_min, r_hour, r_day, r_month;
    logic [15:0] r_year;
    logic        r_sec_pulse, r_day_pulse, r_set_err;

    logic        w_adv;
    logic        w_min_carry, w_hour_carry, w_day_carry, w_month_carry, w_year_carry;
    logic [7:0]  w_sec_next, w_min_next, w_hour_next, w_day_next, w_month_next;
    logic [15:0] w_year_next;
    logic        w_load_ok;

    assign w_adv = tick_1hz & ~r_tick_d & run;

    always_comb begin
        w_min_carry   = (r_sec == 8'h59);
        w_hour_carry  = w_min_carry  && (r_min == 8'h59);
        w_day_carry   = w_hour_carry && (r_hour == 8'h23);
        w_month_carry = w_day_carry  && (r_day == days_in_month(r_month, r_year));
        w_year_carry  = w_month_carry && (r_month == 8'h12);

        w_sec_next   = w_min_carry ? 8'h00 : bcd_inc8(r_sec);
        w_min_next   = r_min;
        w_hour_next  = r_hour;
        w_day_next   = r_day;
        w_month_next = r_month;
        w_year_next  = r_year;
        if (w_min_carry)   w_min_next   = (r_min == 8'h59)   ? 8'h00 : bcd_inc8(r_min);
        if (w_hour_carry)  w_hour_next  = (r_hour == 8'h23)  ? 8'h00 : bcd_inc8(r_hour);
        if (w_day_carry)   w_day_next   = w_month_carry      ? 8'h01 : bcd_inc8(r_day);
        if (w_month_carry) w_month_next = (r_month == 8'h12) ? 8'h01 : bcd_inc8(r_month);
        if (w_year_carry)  w_year_next  = bcd_inc16(r_year);
    end

    // Digit validity is checked first so the BCD magnitude compares below are meaningful.
    always_comb begin
        w_load_ok = digits_ok8(set_sec) && digits_ok8(set_min) && digits_ok8(set_hour)
                 && digits_ok8(set_day) && digits_ok8(set_month)
                 && digits_ok8(set_year[15:8]) && digits_ok8(set_year[7:0])
                 && (set_sec <= 8'h59) && (set_min <= 8'h59) && (set_hour <= 8'h23)
                 && (set_month >= 8'h01) && (set_month <= 8'h12)
                 && (set_day >= 8'h01)
                 && (set_day <= days_in_month(set_month, set_year));
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_tick_d    <= 1'b0;
            r_sec       <= 8'h00;
            r_min       <= 8'h00;
            r_hour      <= 8'h00;
            r_day       <= RST_DAY;
            r_month     <= RST_MONTH;
            r_year      <= RST_YEAR;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_tick_d    <= tick_1hz;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= 1'b0;
            // A load, accepted or not, swallows any tick edge in the same cycle.
            if (set_load) begin
                if (w_load_ok) begin
                    r_sec   <= set_sec;
                    r_min   <= set_min;
                    r_hour  <= set_hour;
                    r_day   <= set_day;
                    r_month <= set_month;
                    r_year  <= set_year;
                end else begin
                    r_set_err <= 1'b1;
                end
            end else if (w_adv) begin
                r_sec       <= w_sec_next;
                r_min       <= w_min_next;
                r_hour      <= w_hour_next;
                r_day       <= w_day_next;
                r_month     <= w_month_next;
                r_year      <= w_year_next;
                r_sec_pulse <= 1'b1;
                r_day_pulse <= w_day_carry;
            end
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar: table of load/tick vectors plus hand-written
// sequences for collision, long-high tick, pause/resume and asynchronous reset.
module tb_rtc_calendar;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic        run;
    logic        set_load;
    logic [7:0]  set_sec, set_min, set_hour, set_day, set_month;
    logic [15:0] set_year;
    logic [7:0]  sec, min, hour, day, month;
    logic [15:0] year;
    logic        sec_pulse, day_pulse, set_err;

    int checks = 0;
    int failures = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    rtc_calendar dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .run       (run),
        .set_load  (set_load),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_day   (set_day),
        .set_month (set_month),
        .set_year  (set_year),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .month     (month),
        .year      (year),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .set_err   (set_err)
    );

    typedef struct {
        logic [15:0] y;
        logic [7:0]  mo, d, h, mi, s;
        logic        err;
        logic [55:0] exp_next;   // {year,month,day,hour,min,sec} after one tick
        logic        exp_day;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [55:0] now_fields();
        return {year, month, day, hour, min, sec};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic drive_set(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                             input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        set_year = y; set_month = mo; set_day = d;
        set_hour = h; set_min = mi; set_sec = s;
    endtask

    logic [55:0] cur_exp;
    int          pcnt;
    localparam logic [55:0] RESET_FIELDS = {16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

    initial begin
        vecs[0]  = '{16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0, {16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[1]  = '{16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0, {16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[2]  = '{16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0, {16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[3]  = '{16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59, 1'b0, {16'h2024, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[4]  = '{16'h2023, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[5]  = '{16'h2023, 8'h13, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[6]  = '{16'h2023, 8'h05, 8'h01, 8'h1A, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[7]  = '{16'h2023, 8'h04, 8'h30, 8'h10, 8'h59, 8'h59, 1'b0, {16'h2023, 8'h04, 8'h30, 8'h11, 8'h00, 8'h00}, 1'b0};
        vecs[8]  = '{16'h2023, 8'h12, 8'h31, 8'h12, 8'h00, 8'h58, 1'b0, {16'h2023, 8'h12, 8'h31, 8'h12, 8'h00, 8'h59}, 1'b0};
        vecs[9]  = '{16'h2023, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[10] = '{16'h2023, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[11] = '{16'h2024, 8'h01, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0, {16'h2024, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[12] = '{16'h1900, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 1'b1, 56'h0, 1'b0};
        vecs[13] = '{16'h2023, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0, {16'h2023, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1};

        rst = 1'b1; tick_1hz = 1'b0; run = 1'b1; set_load = 1'b0;
        drive_set(16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) step();
        rst = 1'b0;
        chk("reset_fields", now_fields(), RESET_FIELDS);
        chk("reset_pulses", {sec_pulse, day_pulse, set_err}, 3'b000);
        step();
        chk("idle_no_change", now_fields(), RESET_FIELDS);
        cur_exp = RESET_FIELDS;

        for (int i = 0; i < 14; i++) begin
            drive_set(vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi, vecs[i].s);
            set_load = 1'b1;
            step();
            set_load = 1'b0;
            chk($sformatf("vec%0d_set_err", i), set_err, vecs[i].err);
            if (!vecs[i].err)
                cur_exp = {vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi, vecs[i].s};
            chk($sformatf("vec%0d_load_fields", i), now_fields(), cur_exp);
            chk($sformatf("vec%0d_load_pulses", i), {sec_pulse, day_pulse}, 2'b00);
            step();
            chk($sformatf("vec%0d_err_clear", i), set_err, 1'b0);
            if (!vecs[i].err) begin
                tick_1hz = 1'b1;
                step();
                cur_exp = vecs[i].exp_next;
                chk($sformatf("vec%0d_tick_fields", i), now_fields(), cur_exp);
                chk($sformatf("vec%0d_sec_pulse", i), sec_pulse, 1'b1);
                chk($sformatf("vec%0d_day_pulse", i), day_pulse, vecs[i].exp_day);
                tick_1hz = 1'b0;
                step();
                chk($sformatf("vec%0d_pulses_clear", i), {sec_pulse, day_pulse}, 2'b00);
                chk($sformatf("vec%0d_hold", i), now_fields(), cur_exp);
            end
            $display("vector %0d applied: err=%0b fields=%h", i, vecs[i].err, cur_exp);
        end

        // load and tick rising edge in the same cycle
        drive_set(16'h2024, 8'h05, 8'h05, 8'h12, 8'h34, 8'h56);
        set_load = 1'b1; tick_1hz = 1'b1;
        step();
        set_load = 1'b0;
        cur_exp = {16'h2024, 8'h05, 8'h05, 8'h12, 8'h34, 8'h56};
        chk("collide_fields", now_fields(), cur_exp);
        chk("collide_sec_pulse", sec_pulse, 1'b0);
        chk("collide_set_err", set_err, 1'b0);
        step();
        chk("collide_after_fields", now_fields(), cur_exp);
        chk("collide_after_pulse", sec_pulse, 1'b0);
        tick_1hz = 1'b0;
        step();
        $display("collision sequence done: fields=%h", now_fields());

        // tick held high for 1000 cycles
        pcnt = 0;
        tick_1hz = 1'b1;
        repeat (1000) begin
            step();
            if (sec_pulse) pcnt++;
        end
        tick_1hz = 1'b0;
        step();
        cur_exp = {16'h2024, 8'h05, 8'h05, 8'h12, 8'h34, 8'h57};
        chk("longhigh_pulses", pcnt, 1);
        chk("longhigh_fields", now_fields(), cur_exp);
        $display("long-high sequence done: pulses=%0d", pcnt);

        // paused: five full ticks
        run = 1'b0;
        pcnt = 0;
        repeat (5) begin
            tick_1hz = 1'b0;
            repeat (3) begin step(); if (sec_pulse) pcnt++; end
            tick_1hz = 1'b1;
            repeat (3) begin step(); if (sec_pulse) pcnt++; end
        end
        chk("paused_pulses", pcnt, 0);
        chk("paused_fields", now_fields(), cur_exp);

        // resume while tick is high: no advance until next rising edge
        run = 1'b1;
        pcnt = 0;
        repeat (5) begin step(); if (sec_pulse) pcnt++; end
        chk("resume_pulses", pcnt, 0);
        chk("resume_fields", now_fields(), cur_exp);
        tick_1hz = 1'b0;
        step();
        tick_1hz = 1'b1;
        step();
        cur_exp = {16'h2024, 8'h05, 8'h05, 8'h12, 8'h34, 8'h58};
        chk("resume_edge_fields", now_fields(), cur_exp);
        chk("resume_edge_pulse", sec_pulse, 1'b1);
        tick_1hz = 1'b0;
        step();
        $display("pause/resume sequence done: fields=%h", now_fields());

        // asynchronous reset while sec_pulse is high
        drive_set(16'h2024, 8'h05, 8'h05, 8'h07, 8'h15, 8'h42);
        set_load = 1'b1;
        step();
        set_load = 1'b0;
        step();
        tick_1hz = 1'b1;
        step();
        chk("prereset_fields", now_fields(), {16'h2024, 8'h05, 8'h05, 8'h07, 8'h15, 8'h43});
        chk("prereset_pulse", sec_pulse, 1'b1);
        #4 rst = 1'b1;
        #1;
        chk("async_reset_fields", now_fields(), RESET_FIELDS);
        chk("async_reset_pulses", {sec_pulse, day_pulse, set_err}, 3'b000);
        tick_1hz = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("post_reset_hold", now_fields(), RESET_FIELDS);
        tick_1hz = 1'b1;
        step();
        chk("post_reset_tick", now_fields(), {16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01});
        chk("post_reset_pulse", sec_pulse, 1'b1);
        tick_1hz = 1'b0;
        step();
        $display("reset sequence done: fields=%h", now_fields());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
